xf100_exu_decode_stage: RTL and testbench
=========================================

Name: xf100_exu_decode_stage

Overview:
Registered, handshaked RV32I decode stage placed between IFU instruction buffer and EXU dispatch/regfile read. Decodes the full RV32I base set (ALU-R/I, LUI, AUIPC, JAL, JALR, branches, loads, stores, FENCE, ECALL/EBREAK), plus RV32M when enabled, and flags illegal encodings. Holds a 2-entry skid buffer so in_ready is a registered signal. Carries PC alongside each decoded instruction.

Parameters:
XLEN, 32, datapath / immediate / PC width (32 only legal value this generation; checked by elaboration assert)
M_EXT, 0, 1 = decode MUL/DIV/REM (funct7 0000001, opcode 0110011); 0 = those encodings raise illegal
INFO_W, 16, width of dec_o_info bus (fields defined in xf100_defines.v)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
dec_i_valid  input  1  instruction present
dec_o_ready  output  1  stage can accept (registered)
dec_i_instr  input  32  raw instruction
dec_i_pc  input  XLEN  instruction PC
dec_i_flush  input  1  discard all held entries
dec_o_valid  output  1  decoded entry present
dec_i_ready  input  1  dispatch accepts
dec_o_pc  output  XLEN  PC of output entry
dec_o_class  output  4  one-hot {MUL, LSU, BJP, ALU}; all-zero for FENCE/ECALL/EBREAK/illegal
dec_o_info  output  INFO_W  op-specific one-hot/flag bits incl. HAS_IMM
dec_o_rs1_en / dec_o_rs2_en / dec_o_rd_en  output  1 each  register usage
dec_o_rs1_idx / dec_o_rs2_idx / dec_o_rd_idx  output  5 each  register indices
dec_o_imm  output  XLEN  sign/zero-extended immediate
dec_o_illegal  output  1  illegal instruction

Behaviour:
- Reset (rst=1 at clk edge): dec_o_valid=0, dec_o_ready=1, skid empty; all data outputs 0.
- Transfer in when dec_i_valid & dec_o_ready; out when dec_o_valid & dec_i_ready.
- Latency 1 cycle: accepted instr appears on outputs next cycle when output register empty or draining.
- Skid: if output register held (dec_o_valid & ~dec_i_ready) and input accepted, entry goes to skid; dec_o_ready=0 next cycle. When output drains, skid moves to output register same edge; dec_o_ready=1 following cycle. Strict FIFO order; no drop/duplicate.
- Simultaneous in/out with empty skid: output register reloads with new entry, no bubble.
- Flush: priority over everything; next cycle dec_o_valid=0, skid empty, dec_o_ready=1; an input presented in flush cycle is discarded.
- Output data stable while dec_o_valid & ~dec_i_ready.
- Imm: I sign-ext instr[31:20]; S {instr[31:25],instr[11:7]}; B sign-ext, bit0=0; U {instr[31:12],12'h0}; J sign-ext, bit0=0; shift-imm zero-ext instr[24:20]; CSR/none 0.
- rd_en = writes rd & rd_idx!=0 (no rd: branch, store, FENCE, ECALL, EBREAK).
- rs1_en = uses rs1 & rs1_idx!=0 (no rs1: LUI, AUIPC, JAL, FENCE, ECALL, EBREAK).
- rs2_en = (R-type | branch | store | M-op) & rs2_idx!=0.
- Illegal: unknown opcode, reserved funct3/funct7 (e.g. SLLI funct7!=0, branch funct3 010/011), M-op when M_EXT=0, instr[1:0]!=11. Illegal entries still pass through with illegal=1, all enables 0, class 0.
- Decode logic purely combinational on input; only stage/skid registers sequential.

Decomposition:
- xf100_defines.v: XF100_DEC_INFO_* field indices (ADD..LUI, AUIPC, JAL, JALR, BEQ..BGEU, LOAD/STORE size+sign, MUL..REMU), class bit indices, opcode constants.
- Sub-module xf100_exu_dec_core: combinational instr -> {class, info, enables, idx, imm, illegal}, parametrised by M_EXT; decode_stage instantiates it and holds output register + skid.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), dec_i_ready=1 -> next cycle valid, class ALU, ADD|HAS_IMM, imm 0xFFFFFFFF, rs1_en=1 idx 2, rd_en=1 idx 1, rs2_en=0.
- beq x1,x2,-8 (0xFE208CE3) -> class BJP, BEQ, imm 0xFFFFFFF8, rs1/rs2_en=1, rd_en=0; sub x3,x1,x0 (0x400081B3) -> rs2_en=0.
- mul x5,x6,x7 (0x027302B3): M_EXT=0 -> illegal=1, class 0; M_EXT=1 -> class MUL, MUL bit, rs2_en=1.
- Backpressure: dec_i_ready=0 4 cycles, push PCs 0x100,0x104,0x108 -> dec_o_ready drops after 2nd accept, 0x108 held upstream; release -> outputs 0x100,0x104,0x108 back-to-back in order.
- Flush with output+skid full -> next cycle dec_o_valid=0, dec_o_ready=1; subsequent instr decodes normally.
- rst asserted mid-stall with skid full -> next cycle dec_o_valid=0, dec_o_ready=1, outputs 0.

Source files
------------

// File: rtl/xf100_exu_decode_stage_pkg.sv
// Shared types and field indices for the XF100 EXU decode stage.
package xf100_exu_decode_stage_pkg;

  localparam int DEC_INFO_BITS = 16;

  // Bit positions in the one-hot class vector
  localparam int CLS_ALU = 0;
  localparam int CLS_BJP = 1;
  localparam int CLS_LSU = 2;
  localparam int CLS_MUL = 3;

  // Info bits are interpreted per class; HAS_IMM is common to all classes
  localparam int INFO_HAS_IMM = 15;
  // ALU class
  localparam int INFO_ADD   = 0;
  localparam int INFO_SUB   = 1;
  localparam int INFO_XOR   = 2;
  localparam int INFO_SLL   = 3;
  localparam int INFO_SRL   = 4;
  localparam int INFO_SRA   = 5;
  localparam int INFO_OR    = 6;
  localparam int INFO_AND   = 7;
  localparam int INFO_SLT   = 8;
  localparam int INFO_SLTU  = 9;
  localparam int INFO_LUI   = 10;
  localparam int INFO_AUIPC = 11;
  // BJP class
  localparam int INFO_JAL  = 0;
  localparam int INFO_JALR = 1;
  localparam int INFO_BEQ  = 2;
  localparam int INFO_BNE  = 3;
  localparam int INFO_BLT  = 4;
  localparam int INFO_BGE  = 5;
  localparam int INFO_BLTU = 6;
  localparam int INFO_BGEU = 7;
  // LSU class: size field is 00 byte, 01 half, 10 word
  localparam int INFO_LOAD     = 0;
  localparam int INFO_STORE    = 1;
  localparam int INFO_SIZE_LSB = 2;
  localparam int INFO_USIGN    = 4;
  // MUL class: bit index equals funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
  localparam int INFO_MUL = 0;
  // Class-less system ops
  localparam int INFO_FENCE  = 0;
  localparam int INFO_ECALL  = 1;
  localparam int INFO_EBREAK = 2;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [3:0]               cls;
    logic [DEC_INFO_BITS-1:0] info;
    logic                     rs1_en;
    logic                     rs2_en;
    logic                     rd_en;
    logic [4:0]               rs1_idx;
    logic [4:0]               rs2_idx;
    logic [4:0]               rd_idx;
    logic [31:0]              imm;
    logic                     illegal;
  } dec_t;

endpackage

// File: rtl/xf100_exu_dec_core.sv
// Combinational RV32I(+M) decoder: raw instruction -> decoded entry.
module xf100_exu_dec_core
  import xf100_exu_decode_stage_pkg::*;
#(
  parameter bit M_EXT = 1'b0
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'h000};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'd0, instr[24:20]};

  logic [3:0]               cls;
  logic [DEC_INFO_BITS-1:0] info;
  logic [31:0]              imm;
  logic                     uses_rs1, uses_rs2, writes_rd, ill;

  // Opcode/funct decode into class, op bits, operand usage and immediate
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    cls       = '0;
    info      = '0;
    imm       = '0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    ill       = 1'b0;
    case (opcode_e'(instr[6:0]))
      OPC_LUI: begin
        cls[CLS_ALU] = 1'b1; info[INFO_LUI] = 1'b1; info[INFO_HAS_IMM] = 1'b1;
        writes_rd = 1'b1; imm = imm_u;
      end
      OPC_AUIPC: begin
        cls[CLS_ALU] = 1'b1; info[INFO_AUIPC] = 1'b1; info[INFO_HAS_IMM] = 1'b1;
        writes_rd = 1'b1; imm = imm_u;
      end
      OPC_JAL: begin
        cls[CLS_BJP] = 1'b1; info[INFO_JAL] = 1'b1; info[INFO_HAS_IMM] = 1'b1;
        writes_rd = 1'b1; imm = imm_j;
      end
      OPC_JALR: begin
        cls[CLS_BJP] = 1'b1; info[INFO_JALR] = 1'b1; info[INFO_HAS_IMM] = 1'b1;
        uses_rs1 = 1'b1; writes_rd = 1'b1; imm = imm_i;
        ill = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        cls[CLS_BJP] = 1'b1; info[INFO_HAS_IMM] = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_b;
        case (funct3)
          3'b000:  info[INFO_BEQ]  = 1'b1;
          3'b001:  info[INFO_BNE]  = 1'b1;
          3'b100:  info[INFO_BLT]  = 1'b1;
          3'b101:  info[INFO_BGE]  = 1'b1;
          3'b110:  info[INFO_BLTU] = 1'b1;
          3'b111:  info[INFO_BGEU] = 1'b1;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        cls[CLS_LSU] = 1'b1; info[INFO_LOAD] = 1'b1; info[INFO_HAS_IMM] = 1'b1;
        uses_rs1 = 1'b1; writes_rd = 1'b1; imm = imm_i;
        case (funct3)
          3'b000:  info[INFO_SIZE_LSB +: 2] = 2'b00;
          3'b001:  info[INFO_SIZE_LSB +: 2] = 2'b01;
          3'b010:  info[INFO_SIZE_LSB +: 2] = 2'b10;
          3'b100:  begin info[INFO_SIZE_LSB +: 2] = 2'b00; info[INFO_USIGN] = 1'b1; end
          3'b101:  begin info[INFO_SIZE_LSB +: 2] = 2'b01; info[INFO_USIGN] = 1'b1; end
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        cls[CLS_LSU] = 1'b1; info[INFO_STORE] = 1'b1; info[INFO_HAS_IMM] = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_s;
        info[INFO_SIZE_LSB +: 2] = funct3[1:0];
        ill = (funct3[2] || funct3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        cls[CLS_ALU] = 1'b1; info[INFO_HAS_IMM] = 1'b1;
        uses_rs1 = 1'b1; writes_rd = 1'b1; imm = imm_i;
        case (funct3)
          3'b000: info[INFO_ADD]  = 1'b1;
          3'b010: info[INFO_SLT]  = 1'b1;
          3'b011: info[INFO_SLTU] = 1'b1;
          3'b100: info[INFO_XOR]  = 1'b1;
          3'b110: info[INFO_OR]   = 1'b1;
          3'b111: info[INFO_AND]  = 1'b1;
          3'b001: begin
            imm = imm_sh; info[INFO_SLL] = 1'b1;
            ill = (funct7 != 7'b0000000);
          end
          default: begin
            imm = imm_sh;
            if (funct7 == 7'b0000000)      info[INFO_SRL] = 1'b1;
            else if (funct7 == 7'b0100000) info[INFO_SRA] = 1'b1;
            else                           ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (M_EXT) begin
            cls[CLS_MUL] = 1'b1; info[INFO_MUL + int'(funct3)] = 1'b1;
          end else begin
            ill = 1'b1;
          end
        end else if (funct7 == 7'b0000000) begin
          cls[CLS_ALU] = 1'b1;
          case (funct3)
            3'b000:  info[INFO_ADD]  = 1'b1;
            3'b001:  info[INFO_SLL]  = 1'b1;
            3'b010:  info[INFO_SLT]  = 1'b1;
            3'b011:  info[INFO_SLTU] = 1'b1;
            3'b100:  info[INFO_XOR]  = 1'b1;
            3'b101:  info[INFO_SRL]  = 1'b1;
            3'b110:  info[INFO_OR]   = 1'b1;
            default: info[INFO_AND]  = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          cls[CLS_ALU] = 1'b1; info[INFO_SUB] = 1'b1;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          cls[CLS_ALU] = 1'b1; info[INFO_SRA] = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        info[INFO_FENCE] = 1'b1;
        ill = (funct3 != 3'b000);
      end
      OPC_SYSTEM: begin
        if (instr == INSTR_ECALL)       info[INFO_ECALL]  = 1'b1;
        else if (instr == INSTR_EBREAK) info[INFO_EBREAK] = 1'b1;
        else                            ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) ill = 1'b1;
  end

  // Illegal entries carry no class, op bits, immediate or register enables
  always_comb begin
    dec.illegal = ill;
    dec.cls     = ill ? '0 : cls;
    dec.info    = ill ? '0 : info;
    dec.imm     = ill ? '0 : imm;
    dec.rs1_idx = instr[19:15];
    dec.rs2_idx = instr[24:20];
    dec.rd_idx  = instr[11:7];
    dec.rs1_en  = !ill && uses_rs1  && (instr[19:15] != 5'd0);
    dec.rs2_en  = !ill && uses_rs2  && (instr[24:20] != 5'd0);
    dec.rd_en   = !ill && writes_rd && (instr[11:7]  != 5'd0);
  end

endmodule

// File: rtl/xf100_exu_decode_stage.sv
// Registered, handshaked decode stage with a one-entry skid behind the output register.
module xf100_exu_decode_stage
  import xf100_exu_decode_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit M_EXT  = 1'b0,
  parameter int INFO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_i_valid,
  output logic              dec_o_ready,
  input  logic [31:0]       dec_i_instr,
  input  logic [XLEN-1:0]   dec_i_pc,
  input  logic              dec_i_flush,
  output logic              dec_o_valid,
  input  logic              dec_i_ready,
  output logic [XLEN-1:0]   dec_o_pc,
  output logic [3:0]        dec_o_class,
  output logic [INFO_W-1:0] dec_o_info,
  output logic              dec_o_rs1_en,
  output logic              dec_o_rs2_en,
  output logic              dec_o_rd_en,
  output logic [4:0]        dec_o_rs1_idx,
  output logic [4:0]        dec_o_rs2_idx,
  output logic [4:0]        dec_o_rd_idx,
  output logic [XLEN-1:0]   dec_o_imm,
  output logic              dec_o_illegal
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("xf100_exu_decode_stage: XLEN must be 32");
  end
  if (INFO_W < DEC_INFO_BITS) begin : g_bad_info_w
    $error("xf100_exu_decode_stage: INFO_W must be at least 16");
  end

  dec_t            dec_in, out_q, skid_q;
  logic            out_vld, skid_vld;
  logic [XLEN-1:0] out_pc, skid_pc;
  logic            in_fire, out_fire;

  xf100_exu_dec_core #(.M_EXT(M_EXT)) u_core (
    .instr (dec_i_instr),
    .dec   (dec_in)
  );

  // Ready comes straight from the skid flop: upstream only stalls once the skid is occupied
  assign dec_o_ready = !skid_vld;
  assign in_fire     = dec_i_valid && dec_o_ready;
  assign out_fire    = out_vld && dec_i_ready;

  // Output register + skid: flush wins, skid drains into output first, then new entries
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset too because the outputs must read zero out of reset, not just be invalid.
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
      out_pc   <= '0;
      skid_pc  <= '0;
    end else if (dec_i_flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      // NOTE: non-blocking assignments let the skid move into the output register and clear in the same edge.
      if (out_fire) begin
        out_q    <= skid_q;
        out_pc   <= skid_pc;
        skid_vld <= 1'b0;
      end
    end else if (in_fire) begin
      if (!out_vld || out_fire) begin
        out_q   <= dec_in;
        out_pc  <= dec_i_pc;
        out_vld <= 1'b1;
      end else begin
        skid_q   <= dec_in;
        skid_pc  <= dec_i_pc;
        skid_vld <= 1'b1;
      end
    end else if (out_fire) begin
      out_vld <= 1'b0;
    end
  end

  assign dec_o_valid   = out_vld;
  assign dec_o_pc      = out_pc;
  assign dec_o_class   = out_q.cls;
  assign dec_o_info    = INFO_W'(out_q.info);
  assign dec_o_rs1_en  = out_q.rs1_en;
  assign dec_o_rs2_en  = out_q.rs2_en;
  assign dec_o_rd_en   = out_q.rd_en;
  assign dec_o_rs1_idx = out_q.rs1_idx;
  assign dec_o_rs2_idx = out_q.rs2_idx;
  assign dec_o_rd_idx  = out_q.rd_idx;
  assign dec_o_imm     = out_q.imm;
  assign dec_o_illegal = out_q.illegal;

endmodule

// File: tb/tb_xf100_exu_decode_stage.sv
// Scoreboard bench for the decode stage; a second instance with M_EXT=1 shares the inputs.
module tb_xf100_exu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_i_valid, dec_i_flush, dec_i_ready;
  logic [31:0] dec_i_instr, dec_i_pc;

  logic        dec_o_ready, dec_o_valid, dec_o_rs1_en, dec_o_rs2_en, dec_o_rd_en, dec_o_illegal;
  logic [31:0] dec_o_pc, dec_o_imm;
  logic [3:0]  dec_o_class;
  logic [15:0] dec_o_info;
  logic [4:0]  dec_o_rs1_idx, dec_o_rs2_idx, dec_o_rd_idx;

  logic        m1_ready, m1_valid, m1_rs1_en, m1_rs2_en, m1_rd_en, m1_illegal;
  logic [31:0] m1_pc, m1_imm;
  logic [3:0]  m1_class;
  logic [15:0] m1_info;
  logic [4:0]  m1_rs1_idx, m1_rs2_idx, m1_rd_idx;

  always #5 clk = ~clk;

  xf100_exu_decode_stage #(.XLEN(32), .M_EXT(1'b0), .INFO_W(16)) dut (
    .clk(clk), .rst(rst), .dec_i_valid(dec_i_valid), .dec_o_ready(dec_o_ready),
    .dec_i_instr(dec_i_instr), .dec_i_pc(dec_i_pc), .dec_i_flush(dec_i_flush),
    .dec_o_valid(dec_o_valid), .dec_i_ready(dec_i_ready), .dec_o_pc(dec_o_pc),
    .dec_o_class(dec_o_class), .dec_o_info(dec_o_info), .dec_o_rs1_en(dec_o_rs1_en),
    .dec_o_rs2_en(dec_o_rs2_en), .dec_o_rd_en(dec_o_rd_en), .dec_o_rs1_idx(dec_o_rs1_idx),
    .dec_o_rs2_idx(dec_o_rs2_idx), .dec_o_rd_idx(dec_o_rd_idx), .dec_o_imm(dec_o_imm),
    .dec_o_illegal(dec_o_illegal)
  );

  xf100_exu_decode_stage #(.XLEN(32), .M_EXT(1'b1), .INFO_W(16)) dut_m (
    .clk(clk), .rst(rst), .dec_i_valid(dec_i_valid), .dec_o_ready(m1_ready),
    .dec_i_instr(dec_i_instr), .dec_i_pc(dec_i_pc), .dec_i_flush(dec_i_flush),
    .dec_o_valid(m1_valid), .dec_i_ready(dec_i_ready), .dec_o_pc(m1_pc),
    .dec_o_class(m1_class), .dec_o_info(m1_info), .dec_o_rs1_en(m1_rs1_en),
    .dec_o_rs2_en(m1_rs2_en), .dec_o_rd_en(m1_rd_en), .dec_o_rs1_idx(m1_rs1_idx),
    .dec_o_rs2_idx(m1_rs2_idx), .dec_o_rd_idx(m1_rd_idx), .dec_o_imm(m1_imm),
    .dec_o_illegal(m1_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  cls;
    logic [15:0] info;
    logic        rs1_en, rs2_en, rd_en;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } sb_t;

  localparam int NVEC = 17;
  localparam logic [31:0] MUL_INSTR = 32'h0273_02B3;

  vec_t vecs [NVEC];
  vec_t cur_exp;
  sb_t  sb [$];
  sb_t  mon_e;
  sb_t  push_e;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] cls, input logic [15:0] info,
                              input logic rs1, input logic rs2, input logic rd,
                              input logic [31:0] imm, input logic ill);
    vec_t v;
    v.instr = instr; v.cls = cls; v.info = info;
    v.rs1_en = rs1; v.rs2_en = rs2; v.rd_en = rd; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  // Hand-decoded expectations; class {MUL,LSU,BJP,ALU}, HAS_IMM is info bit 15
  initial begin
    vecs[0]  = mk(32'hFFF1_0093, 4'b0001, 16'h8001, 1, 0, 1, 32'hFFFF_FFFF, 0); // addi x1,x2,-1
    vecs[1]  = mk(32'hFE20_8CE3, 4'b0010, 16'h8004, 1, 1, 0, 32'hFFFF_FFF8, 0); // beq x1,x2,-8
    vecs[2]  = mk(32'h4000_81B3, 4'b0001, 16'h0002, 1, 0, 1, 32'h0,         0); // sub x3,x1,x0
    vecs[3]  = mk(MUL_INSTR,     4'b0000, 16'h0000, 0, 0, 0, 32'h0,         1); // mul, no M
    vecs[4]  = mk(32'h1234_52B7, 4'b0001, 16'h8400, 0, 0, 1, 32'h1234_5000, 0); // lui x5
    vecs[5]  = mk(32'h0081_2203, 4'b0100, 16'h8009, 1, 0, 1, 32'h8,         0); // lw x4,8(x2)
    vecs[6]  = mk(32'hFE50_AE23, 4'b0100, 16'h800A, 1, 1, 0, 32'hFFFF_FFFC, 0); // sw x5,-4(x1)
    vecs[7]  = mk(32'h4030_9093, 4'b0000, 16'h0000, 0, 0, 0, 32'h0,         1); // slli bad funct7
    vecs[8]  = mk(32'h41F1_D113, 4'b0001, 16'h8020, 1, 0, 1, 32'h1F,        0); // srai x2,x3,31
    vecs[9]  = mk(32'hFE20_ACE3, 4'b0000, 16'h0000, 0, 0, 0, 32'h0,         1); // branch f3=010
    vecs[10] = mk(32'h0100_00EF, 4'b0010, 16'h8001, 0, 0, 1, 32'h10,        0); // jal x1,+16
    vecs[11] = mk(32'h0000_0073, 4'b0000, 16'h0002, 0, 0, 0, 32'h0,         0); // ecall
    vecs[12] = mk(32'h0000_0000, 4'b0000, 16'h0000, 0, 0, 0, 32'h0,         1); // instr[1:0]!=11
    vecs[13] = mk(32'h0000_0013, 4'b0001, 16'h8001, 0, 0, 0, 32'h0,         0); // addi x0,x0,0
    vecs[14] = mk(32'h0FF0_000F, 4'b0000, 16'h0001, 0, 0, 0, 32'h0,         0); // fence
    vecs[15] = mk(32'hFFF3_C303, 4'b0100, 16'h8011, 1, 0, 1, 32'hFFFF_FFFF, 0); // lbu x6,-1(x7)
    vecs[16] = mk(32'h0030_9093, 4'b0001, 16'h8008, 1, 0, 1, 32'h3,         0); // slli x1,x1,3
  end

  // Scoreboard: push on accepted input, pop and compare on output transfer
  always @(negedge clk) begin
    if (rst || dec_i_flush) begin
      sb.delete();
    end else begin
      if (dec_o_valid && dec_i_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("pc%0h_pc", mon_e.pc),      dec_o_pc,      mon_e.pc);
          check($sformatf("pc%0h_cls", mon_e.pc),     dec_o_class,   mon_e.v.cls);
          check($sformatf("pc%0h_info", mon_e.pc),    dec_o_info,    mon_e.v.info);
          check($sformatf("pc%0h_imm", mon_e.pc),     dec_o_imm,     mon_e.v.imm);
          check($sformatf("pc%0h_ill", mon_e.pc),     dec_o_illegal, mon_e.v.ill);
          check($sformatf("pc%0h_rs1en", mon_e.pc),   dec_o_rs1_en,  mon_e.v.rs1_en);
          check($sformatf("pc%0h_rs2en", mon_e.pc),   dec_o_rs2_en,  mon_e.v.rs2_en);
          check($sformatf("pc%0h_rden", mon_e.pc),    dec_o_rd_en,   mon_e.v.rd_en);
          check($sformatf("pc%0h_rs1idx", mon_e.pc),  dec_o_rs1_idx, mon_e.v.instr[19:15]);
          check($sformatf("pc%0h_rs2idx", mon_e.pc),  dec_o_rs2_idx, mon_e.v.instr[24:20]);
          check($sformatf("pc%0h_rdidx", mon_e.pc),   dec_o_rd_idx,  mon_e.v.instr[11:7]);
          if (mon_e.v.instr == MUL_INSTR) begin
            check("mext_valid",  m1_valid,   1);
            check("mext_cls",    m1_class,   4'b1000);
            check("mext_info",   m1_info,    16'h0001);
            check("mext_ill",    m1_illegal, 0);
            check("mext_rs2en",  m1_rs2_en,  1);
            check("mext_rden",   m1_rd_en,   1);
          end
        end
      end
      if (dec_i_valid && dec_o_ready) begin
        push_e.v  = cur_exp;
        push_e.pc = dec_i_pc;
        sb.push_back(push_e);
      end
    end
  end

  // Randomised downstream backpressure when enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) dec_i_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present one instruction and hold it until accepted (called at posedge+1, returns at posedge+1)
  task automatic push_instr(input vec_t v, input logic [31:0] pc);
    bit acc;
    acc = 1'b0;
    dec_i_valid = 1'b1; dec_i_instr = v.instr; dec_i_pc = pc; cur_exp = v;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk); acc = dec_o_ready;
      @(posedge clk); #1;
    end
    dec_i_valid = 1'b0;
    check("accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || dec_o_valid) && n < 500) begin
      @(negedge clk); n++;
    end
    check(tag, sb.size(), 0);
    check({tag, "_vld"}, dec_o_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, dec_o_valid,   0);
    check({tag, "_ready"}, dec_o_ready,   1);
    check({tag, "_pc"},    dec_o_pc,      0);
    check({tag, "_imm"},   dec_o_imm,     0);
    check({tag, "_cls"},   dec_o_class,   0);
    check({tag, "_info"},  dec_o_info,    0);
    check({tag, "_rdidx"}, dec_o_rd_idx,  0);
    check({tag, "_rs1en"}, dec_o_rs1_en,  0);
    check({tag, "_ill"},   dec_o_illegal, 0);
  endtask

  initial begin
    rst = 1'b1; dec_i_valid = 1'b0; dec_i_flush = 1'b0; dec_i_ready = 1'b1;
    dec_i_instr = '0; dec_i_pc = '0; cur_exp = mk('0, '0, '0, 0, 0, 0, '0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1;

    // Streaming, dispatch always ready
    for (int i = 0; i < NVEC; i++) push_instr(vecs[i], 32'h1000 + 32'(4 * i));
    drain("drain_stream");

    // Streaming under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < NVEC; i++) push_instr(vecs[i], 32'h2000 + 32'(4 * i));
    drain("drain_random");
    rand_rdy = 1'b0;
    dec_i_ready = 1'b1;
    @(posedge clk); #1;

    // Backpressure: output + skid fill, third held upstream, then drains back-to-back
    dec_i_ready = 1'b0;
    push_instr(vecs[0], 32'h100);
    push_instr(vecs[1], 32'h104);
    @(negedge clk);
    check("bp_ready_low", dec_o_ready, 0);
    check("bp_pc_held", dec_o_pc, 32'h100);
    @(posedge clk); #1;
    dec_i_valid = 1'b1; dec_i_instr = vecs[5].instr; dec_i_pc = 32'h108; cur_exp = vecs[5];
    @(negedge clk);
    check("bp_still_low", dec_o_ready, 0);
    @(posedge clk); #1;
    dec_i_ready = 1'b1;
    @(negedge clk);
    check("b2b_0_valid", dec_o_valid, 1);
    check("b2b_0_pc", dec_o_pc, 32'h100);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_1_valid", dec_o_valid, 1);
    check("b2b_1_pc", dec_o_pc, 32'h104);
    check("b2b_ready_back", dec_o_ready, 1);
    @(posedge clk); #1;
    dec_i_valid = 1'b0;
    @(negedge clk);
    check("b2b_2_valid", dec_o_valid, 1);
    check("b2b_2_pc", dec_o_pc, 32'h108);
    @(posedge clk); #1;
    drain("drain_bp");

    // Flush with output and skid both full
    dec_i_ready = 1'b0;
    push_instr(vecs[2], 32'h200);
    push_instr(vecs[3], 32'h204);
    @(negedge clk);
    check("flush_full_ready", dec_o_ready, 0);
    @(posedge clk); #1;
    dec_i_flush = 1'b1;
    @(posedge clk); #1;
    dec_i_flush = 1'b0;
    @(negedge clk);
    check("flush_valid", dec_o_valid, 0);
    check("flush_ready", dec_o_ready, 1);
    @(posedge clk); #1;

    // Flush with an input presented in the same cycle: the input is dropped
    push_instr(vecs[4], 32'h300);
    dec_i_flush = 1'b1;
    dec_i_valid = 1'b1; dec_i_instr = vecs[6].instr; dec_i_pc = 32'h304; cur_exp = vecs[6];
    @(posedge clk); #1;
    dec_i_flush = 1'b0; dec_i_valid = 1'b0;
    @(negedge clk);
    check("flush_in_discard", dec_o_valid, 0);
    check("flush_in_ready", dec_o_ready, 1);
    @(posedge clk); #1;
    dec_i_ready = 1'b1;
    push_instr(vecs[0], 32'h400);
    @(negedge clk);
    check("post_flush_valid", dec_o_valid, 1);
    check("post_flush_pc", dec_o_pc, 32'h400);
    @(posedge clk); #1;
    drain("drain_flush");

    // Reset in the middle of a stall with the skid full
    dec_i_ready = 1'b0;
    push_instr(vecs[1], 32'h500);
    push_instr(vecs[5], 32'h504);
    @(negedge clk);
    check("rst_stall_ready", dec_o_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_cleared("mid_rst");
    @(posedge clk); #1;

    dec_i_ready = 1'b1;
    push_instr(vecs[15], 32'h600);
    drain("drain_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
